// File: rtl/button_debounce.sv
// Push-button conditioner: two-flop synchronizer, press/release debounce FSM,
// long-press detection and a press-toggled level. All outputs are registered.
module button_debounce #(
    parameter int unsigned FREQ        = 100000000,
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned LONG_MS     = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic toggle
);

    localparam int unsigned DB_CYC   = FREQ / 1000 * DEBOUNCE_MS;
    localparam int unsigned LONG_CYC = FREQ / 1000 * LONG_MS;
    localparam int unsigned CW       = $clog2(LONG_CYC + 1);

    localparam logic [CW-1:0] DB_MAX    = CW'(DB_CYC);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYC - 1);

    typedef enum logic [1:0] {StIdle, StPressDb, StHeld, StReleaseDb} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] hold;
    logic          long_done;
    logic          sync_meta;
    logic          s;

    // Two-flop synchronizer; nothing else looks at btn_in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta <= 1'b0;
            s         <= 1'b0;
        end else begin
            sync_meta <= btn_in;
            s         <= sync_meta;
        end
    end

    // Debounce FSM: a level change needs the new value held for DB_CYC+1 samples of s.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= StIdle;
            cnt           <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            toggle        <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (s) begin
                        state <= StPressDb;
                        cnt   <= CW'(1);
                    end
                end
                StPressDb: begin
                    if (!s) begin
                        // Bounce: drop back silently and restart the window.
                        state <= StIdle;
                        cnt   <= '0;
                    end else if (cnt == DB_MAX) begin
                        state       <= StHeld;
                        btn_level   <= 1'b1;
                        press_pulse <= 1'b1;
                        toggle      <= ~toggle;
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StHeld: begin
                    if (!s) begin
                        state <= StReleaseDb;
                        cnt   <= CW'(1);
                    end
                end
                StReleaseDb: begin
                    if (s) begin
                        state <= StHeld;
                        cnt   <= '0;
                    end else if (cnt == DB_MAX) begin
                        state         <= StIdle;
                        btn_level     <= 1'b0;
                        release_pulse <= 1'b1;
                        cnt           <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= StIdle;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Long-press timer: runs while the debounced level is high (release window
    // included) and fires once; it is cleared once the level has dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold       <= '0;
            long_done  <= 1'b0;
            long_pulse <= 1'b0;
        end else begin
            long_pulse <= 1'b0;
            if (!btn_level) begin
                hold      <= '0;
                long_done <= 1'b0;
            end else if (!long_done) begin
                if (hold == LONG_LAST) begin
                    long_pulse <= 1'b1;
                    long_done  <= 1'b1;
                end
                hold <= hold + 1'b1;
            end
        end
    end

endmodule
